// File: rtl/rf_pkg.sv
// Shared constants, width helpers and bus typedefs for the scoreboarded register file.
package rf_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_NUM_REGS = 8;
    localparam int unsigned DEF_NUM_RD   = 2;

    // Register address width for a file of n registers.
    function automatic int unsigned rf_aw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width needed to count from 0 up to n claimed registers inclusive.
    function automatic int unsigned rf_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Packed read-address bus for the default configuration.
    typedef logic [DEF_NUM_RD*rf_aw(DEF_NUM_REGS)-1:0] rd_addr_bus_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: register select, write-through bypass, r0 masking, busy flag.
module rf_read_port
    import rf_pkg::*;
#(
    parameter  int unsigned DATA_W   = DEF_DATA_W,
    parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter  int unsigned ZERO_R0  = 0,
    localparam int unsigned AW       = rf_aw(NUM_REGS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] i_mem [NUM_REGS],
    input  logic [NUM_REGS-1:0] i_busy,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_busy
);

    logic              w_hit;
    logic              w_zero;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;
    logic [DATA_W-1:0] r_data;
    logic              r_busy;

    // Select the addressed register, forwarding a same-cycle write and masking r0.
    always_comb begin
        w_hit  = i_wr_en && (i_wr_addr == i_rd_addr);
        w_zero = (ZERO_R0 != 0) && (i_rd_addr == '0);
        if (w_zero) begin
            w_data = '0;
            w_busy = 1'b0;
        end else begin
            w_data = w_hit ? i_wr_data : i_mem[i_rd_addr];
            // A write landing this cycle resolves the pending operand.
            w_busy = i_busy[i_rd_addr] && !w_hit;
        end
    end

    // Output flops for data and pending flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_data <= '0;
            r_busy <= 1'b0;
        end else begin
            r_data <= w_data;
            r_busy <= w_busy;
        end
    end

    assign o_rd_data = r_data;
    assign o_rd_busy = r_busy;

endmodule

// File: rtl/rf_scoreboard_regfile.sv
// Multi-read-port register file with write-through bypass and per-register busy scoreboard.
module rf_scoreboard_regfile
    import rf_pkg::*;
#(
    parameter  int unsigned DATA_W   = DEF_DATA_W,
    parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter  int unsigned NUM_RD   = DEF_NUM_RD,
    parameter  int unsigned ZERO_R0  = 0,
    localparam int unsigned AW       = rf_aw(NUM_REGS),
    localparam int unsigned CNT_W    = rf_cnt_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_en,
    input  logic [AW-1:0]            claim_addr,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [CNT_W-1:0]         busy_cnt,
    output logic                     all_idle
);

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_idle;

    logic                w_wr_ok;
    logic                w_cl_ok;
    logic                w_inc;
    logic                w_dec;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // Next scoreboard state; a claim overrides a same-address release, and the
    // count moves only on actual bit transitions so it tracks the popcount.
    always_comb begin
        w_wr_ok    = wr_en    && !((ZERO_R0 != 0) && (wr_addr    == '0));
        w_cl_ok    = claim_en && !((ZERO_R0 != 0) && (claim_addr == '0));
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_cl_ok) begin
            w_busy_nxt[claim_addr] = 1'b1;
        end
        w_inc     = w_cl_ok && !r_busy[claim_addr];
        w_dec     = w_wr_ok && r_busy[wr_addr] && !(w_cl_ok && (claim_addr == wr_addr));
        w_cnt_nxt = r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Scoreboard vector, claim counter and idle flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_busy <= '0;
            r_cnt  <= '0;
            r_idle <= 1'b1;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            r_idle <= (w_cnt_nxt == '0);
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        rf_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ZERO_R0  (ZERO_R0)
        ) u_port (
            .clk       (clk),
            .resetn    (resetn),
            .i_mem     (r_mem),
            .i_busy    (r_busy),
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_rd_addr (rd_addr[p*AW +: AW]),
            .o_rd_data (rd_data[p*DATA_W +: DATA_W]),
            .o_rd_busy (rd_busy[p])
        );
    end

    assign busy_cnt = r_cnt;
    assign all_idle = r_idle;

endmodule

// File: tb/tb_rf_scoreboard_regfile.sv
// Scoreboard bench: two instances (ZERO_R0=0 and 1) share stimulus and are checked
// against a spec-level array model of registers and busy bits.
module tb_rf_scoreboard_regfile;
    import rf_pkg::*;

    localparam int DW  = 16;
    localparam int NR  = 8;
    localparam int NRD = 2;
    localparam int AW  = 3;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic wr_en = 1'b0;
    logic claim_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] claim_addr = '0;
    logic [DW-1:0] wr_data = '0;
    rd_addr_bus_t  rd_addr = '0;

    logic [NRD*DW-1:0] rd_data_a, rd_data_z;
    logic [NRD-1:0]    rd_busy_a, rd_busy_z;
    logic [CW-1:0]     busy_cnt_a, busy_cnt_z;
    logic              all_idle_a, all_idle_z;

    always #5 clk = ~clk;

    rf_scoreboard_regfile #(
        .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_R0(0)
    ) dut_a (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_busy(rd_busy_a), .busy_cnt(busy_cnt_a), .all_idle(all_idle_a)
    );

    rf_scoreboard_regfile #(
        .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_R0(1)
    ) dut_z (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .rd_addr(rd_addr),
        .rd_data(rd_data_z), .rd_busy(rd_busy_z), .busy_cnt(busy_cnt_z), .all_idle(all_idle_z)
    );

    typedef struct {
        int                due;
        logic [NRD*DW-1:0] data;
        logic [NRD-1:0]    busy;
        logic [CW-1:0]     cnt;
        logic              idle;
    } exp_t;

    exp_t qa[$];
    exp_t qz[$];

    logic [DW-1:0] m_mem [2][NR];
    bit            m_bsy [2][NR];

    int ncyc  = 0;
    int total = 0;
    int bad   = 0;

    // Reference model: apply the architectural rules to the current inputs for
    // configuration k (1 = register 0 hardwired), return what the outputs must be
    // after the coming edge, and advance the model state.
    function automatic exp_t model_step(input int k);
        exp_t e;
        bit   z;
        int   n;
        z      = (k == 1);
        e.due  = ncyc + 1;
        e.data = '0;
        e.busy = '0;
        if (!resetn) begin
            for (int r = 0; r < NR; r++) begin
                m_mem[k][r] = '0;
                m_bsy[k][r] = 1'b0;
            end
            e.cnt  = '0;
            e.idle = 1'b1;
            return e;
        end
        for (int p = 0; p < NRD; p++) begin
            int a;
            bit hit;
            a   = int'(rd_addr[p*AW +: AW]);
            hit = wr_en && (int'(wr_addr) == a);
            if (!(z && a == 0)) begin
                e.data[p*DW +: DW] = hit ? wr_data : m_mem[k][a];
                e.busy[p]          = m_bsy[k][a] && !hit;
            end
        end
        if (wr_en && !(z && wr_addr == 0)) begin
            m_mem[k][wr_addr] = wr_data;
            m_bsy[k][wr_addr] = 1'b0;
        end
        if (claim_en && !(z && claim_addr == 0)) begin
            m_bsy[k][claim_addr] = 1'b1;
        end
        n = 0;
        for (int r = 0; r < NR; r++) begin
            n += int'(m_bsy[k][r]);
        end
        e.cnt  = CW'(n);
        e.idle = (n == 0);
        return e;
    endfunction

    task automatic issue(input bit rn, input bit we, input int wa, input int wd,
                         input bit ce, input int ca, input int r0, input int r1);
        @(posedge clk);
        #1;
        resetn     = rn;
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = DW'(wd);
        claim_en   = ce;
        claim_addr = AW'(ca);
        rd_addr    = {AW'(r1), AW'(r0)};
        qa.push_back(model_step(0));
        qz.push_back(model_step(1));
    endtask

    task automatic check(input string tag, input exp_t e,
                         input logic [NRD*DW-1:0] d, input logic [NRD-1:0] b,
                         input logic [CW-1:0] c, input logic i);
        total++;
        if (d !== e.data) begin
            bad++;
            $display("FAIL %s rd_data cyc=%0d got=%h want=%h", tag, ncyc, d, e.data);
        end
        total++;
        if (b !== e.busy) begin
            bad++;
            $display("FAIL %s rd_busy cyc=%0d got=%b want=%b", tag, ncyc, b, e.busy);
        end
        total++;
        if (c !== e.cnt) begin
            bad++;
            $display("FAIL %s busy_cnt cyc=%0d got=%0d want=%0d", tag, ncyc, c, e.cnt);
        end
        total++;
        if (i !== e.idle) begin
            bad++;
            $display("FAIL %s all_idle cyc=%0d got=%b want=%b", tag, ncyc, i, e.idle);
        end
    endtask

    // Monitor: after each edge, retire every expectation due at this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            ncyc++;
            #3;
            while (qa.size() > 0 && qa[0].due <= ncyc) begin
                e = qa.pop_front();
                check("A", e, rd_data_a, rd_busy_a, busy_cnt_a, all_idle_a);
            end
            while (qz.size() > 0 && qz[0].due <= ncyc) begin
                e = qz.pop_front();
                check("Z", e, rd_data_z, rd_busy_z, busy_cnt_z, all_idle_z);
            end
        end
    end

    // Stimulus: directed scenarios, then random traffic.
    initial begin
        int waits;
        // reset held two cycles with write and claim active
        issue(0, 1, 3, 'hAAAA, 1, 4, 0, 1);
        issue(0, 1, 3, 'hAAAA, 1, 4, 0, 1);
        for (int r = 0; r < NR; r++) issue(1, 0, 0, 0, 0, 0, r, (r + 1) % NR);
        // write then read
        issue(1, 1, 3, 'hBEEF, 0, 0, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 3, 5);
        // bypass
        issue(1, 1, 2, 'h1111, 0, 0, 0, 0);
        issue(1, 1, 2, 'h2222, 0, 0, 2, 2);
        issue(1, 0, 0, 0, 0, 0, 2, 2);
        // scoreboard on r4
        issue(1, 0, 0, 0, 1, 4, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 4, 4);
        issue(1, 1, 4, 'h4444, 0, 0, 4, 4);
        issue(1, 0, 0, 0, 0, 0, 4, 0);
        // claim and write r6 together while busy
        issue(1, 0, 0, 0, 1, 6, 6, 6);
        issue(1, 1, 6, 'h6666, 1, 6, 6, 6);
        issue(1, 0, 0, 0, 0, 0, 6, 6);
        // claim r1 with write to non-busy r7
        issue(1, 1, 7, 'h7777, 1, 1, 1, 7);
        issue(1, 0, 0, 0, 0, 0, 1, 7);
        // register 0 write and claim
        issue(1, 1, 0, 'hFFFF, 1, 0, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-operation
        issue(0, 1, 5, 'h5555, 1, 5, 5, 6);
        issue(1, 0, 0, 0, 0, 0, 5, 6);
        // random traffic
        for (int n = 0; n < 600; n++) begin
            issue(($urandom % 64) != 0, $urandom_range(0, 1), $urandom_range(0, NR - 1),
                  $urandom_range(0, 'hFFFF), $urandom_range(0, 1), $urandom_range(0, NR - 1),
                  $urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
        end
        issue(1, 0, 0, 0, 0, 0, 0, 1);
        waits = 0;
        while ((qa.size() > 0 || qz.size() > 0) && waits < 10) begin
            @(posedge clk);
            waits++;
        end
        #5;
        total++;
        if (qa.size() > 0 || qz.size() > 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", qa.size() + qz.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rf_scoreboard_regfile.md
Name: rf_scoreboard_regfile

Overview:
- Parametrised multi-read-port register file with write-to-read bypass and a per-register busy scoreboard.
- Sits between decode/issue and write-back of the pipelined core. Issue claims a destination register; write-back writes it and releases the claim.
- Read ports report pending (busy) operands so the hazard unit can stall.
- Replaces the fixed 8x16, 2-read-port file with a generalised, hazard-aware version.

Parameters:
- DATA_W, 16, width of each register.
- NUM_REGS, 8, number of registers, power of two, at least 2. AW = clog2(NUM_REGS).
- NUM_RD, 2, number of read ports, 1 to 4.
- ZERO_R0, 0. When 1, register 0 always reads 0, and writes and claims to it are ignored.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  reset, synchronous, active-low
- wr_en  in  1  write-back valid
- wr_addr  in  AW  write-back destination
- wr_data  in  DATA_W  write-back value
- claim_en  in  1  issue stage reserves a destination
- claim_addr  in  AW  register being reserved
- rd_addr  in  NUM_RD*AW  packed read addresses; port p is bits [p*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_busy  out  NUM_RD  per-port operand-pending flag, registered
- busy_cnt  out  clog2(NUM_REGS+1)  number of registers currently claimed
- all_idle  out  1  1 when busy_cnt == 0

Behaviour:
- Reset: on a clk edge with resetn=0:
  - all registers are cleared to 0 and all busy bits are cleared;
  - rd_data = 0, rd_busy = 0, busy_cnt = 0, all_idle = 1.
  - Reset asserted mid-operation discards any same-cycle write or claim.
- Write: when wr_en=1, reg[wr_addr] <= wr_data at the clk edge. It is ignored if ZERO_R0 and wr_addr=0.
- Read latency is 1 cycle. rd_data[p] at edge t+1 is the value of reg[rd_addr[p]] sampled at edge t, with this bypass:
  - if wr_en=1 and wr_addr=rd_addr[p] in cycle t, rd_data[p] = wr_data (new value, write-through);
  - if ZERO_R0 and the address is 0, rd_data[p] = 0 regardless of bypass.
- Busy scoreboard, one bit per register:
  - set by claim_en at claim_addr;
  - cleared by wr_en at wr_addr;
  - a claim and a write to the same address in the same cycle leave the bit set (new claim wins);
  - a claim and a write to different addresses both take effect;
  - a claim to an already-busy register leaves it busy (no count change); the pending write then clears it once;
  - a write to a non-busy register is legal: data is written, and the bit and count are unchanged.
- rd_busy[p] at edge t+1 = busy[rd_addr[p]] AND NOT (wr_en AND wr_addr==rd_addr[p]), evaluated in cycle t.
  - A same-cycle claim is NOT visible, so an instruction reading its own destination does not self-stall.
  - The flag is 0 for address 0 when ZERO_R0=1.
- busy_cnt is registered and equals the popcount of the busy vector after each edge. Per cycle the update is:
  - +1 for a claim that sets a previously clear bit;
  - -1 for a write that clears a set bit;
  - net 0 when both occur.
  - The count never exceeds NUM_REGS and never underflows.
- all_idle is registered, equals (busy_cnt == 0), and is updated in the same cycle as busy_cnt.
- Multiple read ports may address the same register; each port is independent.

Decomposition:
- Shared package rf_pkg holds:
  - default DATA_W, NUM_REGS and NUM_RD constants;
  - a function computing AW and the busy_cnt width;
  - a typedef for the packed read-address bus.
- Sub-module rf_read_port, instantiated NUM_RD times in a generate loop. Per port it contains the register-select mux, bypass compare, ZERO_R0 masking and the output flops for data and busy.
- The storage array, scoreboard vector and counter stay in the top module.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with wr_en=1 and claim_en=1 -> rd_data=0, rd_busy=0, busy_cnt=0, all_idle=1; a later read of every register returns 0.
- Write then read: write 0xBEEF to r3, then read r3 on port 0 and r5 on port 1 -> next cycle rd_data port0 = 0xBEEF, port1 = 0x0000.
- Bypass: r2 holds 0x1111; in the same cycle write 0x2222 to r2 and read r2 on both ports -> both ports show 0x2222 one cycle later.
- Scoreboard:
  - claim r4 -> busy_cnt=1, all_idle=0;
  - read r4 -> rd_busy=1;
  - write r4 plus read r4 in the same cycle -> rd_busy=0 with the new data, and busy_cnt=0 after that edge.
- Simultaneous claim and write on r6 while r6 is busy -> r6 stays busy, busy_cnt unchanged.
- Claim r1 and write r7 (non-busy) in the same cycle -> busy_cnt +1.
- ZERO_R0=1: write 0xFFFF to r0 and claim r0 -> reads of r0 return 0, rd_busy=0, busy_cnt=0.
